// File: rtl/vco_freq_ctrl.sv
// vco_freq_ctrl
// Digital frequency-locking loop around a VCO. The controller counts rising
// edges of the divided VCO clock over a fixed window of clk_ref cycles and
// compares the count with a target count. It then steps the VCO control word
// by a scaled error and raises a lock flag after enough consecutive good windows.
module vco_freq_ctrl #(
    parameter int DIG_CTRL_V_WIDTH = 8,
    parameter int CNT_WIDTH        = 16,
    parameter int WINDOW_LEN       = 1024,
    parameter int GAIN_SHIFT       = 2,
    parameter int CTRL_INIT        = 2 ** (DIG_CTRL_V_WIDTH - 1),
    parameter int LOCK_TOL         = 1,
    parameter int LOCK_COUNT       = 4
) (
    input  logic                        clk_ref,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        vco_div_in,
    input  logic [CNT_WIDTH-1:0]        target_cnt,
    output logic [DIG_CTRL_V_WIDTH-1:0] dig_ctrl_voltage,
    output logic [CNT_WIDTH-1:0]        meas_count,
    output logic                        update_valid,
    output logic                        locked
);

    // Signed error is one bit wider than the counts, so it covers +/-(2**CNT_WIDTH-1).
    localparam int ERR_W   = CNT_WIDTH + 1;
    // The sum is wide enough that neither the step nor the control word can overflow it before clamping.
    localparam int SUM_W   = DIG_CTRL_V_WIDTH + CNT_WIDTH + 2;
    localparam int WIN_W   = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam int LOCK_W  = $clog2(LOCK_COUNT + 1);

    localparam logic [WIN_W-1:0]            WIN_LAST    = WIN_W'(WINDOW_LEN - 1);
    localparam logic [LOCK_W-1:0]           LOCK_MAX    = LOCK_W'(LOCK_COUNT);
    localparam logic [ERR_W-1:0]            LOCK_TOL_W  = ERR_W'(LOCK_TOL);
    localparam logic [DIG_CTRL_V_WIDTH-1:0] CTRL_INIT_W = DIG_CTRL_V_WIDTH'(CTRL_INIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_UPDATE
    } state_t;

    state_t                        r_state;
    logic                          r_sync_q1;
    logic                          r_sync_q2;
    logic                          r_sync_q3;
    logic [WIN_W-1:0]              r_win_cnt;
    logic [CNT_WIDTH-1:0]          r_edge_cnt;
    logic [CNT_WIDTH-1:0]          r_meas_count;
    logic [DIG_CTRL_V_WIDTH-1:0]   r_ctrl;
    logic                          r_update_valid;
    logic                          r_locked;
    logic [LOCK_W-1:0]             r_lock_cnt;

    logic                          w_edge;
    logic [CNT_WIDTH-1:0]          w_edge_cnt_inc;
    logic signed [ERR_W-1:0]       w_error;
    logic signed [ERR_W-1:0]       w_step;
    logic [ERR_W-1:0]              w_abs_err;
    logic                          w_in_tol;
    logic signed [SUM_W-1:0]       w_ctrl_ext;
    logic signed [SUM_W-1:0]       w_step_ext;
    logic signed [SUM_W-1:0]       w_sum;
    logic [DIG_CTRL_V_WIDTH-1:0]   w_ctrl_next;
    logic [LOCK_W-1:0]             w_lock_cnt_next;

    // Synchronize the asynchronous divided VCO clock and keep one extra stage for edge detection.
    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            r_sync_q1 <= 1'b0;
            r_sync_q2 <= 1'b0;
            r_sync_q3 <= 1'b0;
        end else begin
            r_sync_q1 <= vco_div_in;
            r_sync_q2 <= r_sync_q1;
            r_sync_q3 <= r_sync_q2;
        end
    end

    assign w_edge = r_sync_q2 & ~r_sync_q3;

    // Edge-count increment, error, gain step, clamped control word and lock counter.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_edge_cnt_inc  = r_edge_cnt;
        w_error         = '0;
        w_step          = '0;
        w_abs_err       = '0;
        w_in_tol        = 1'b0;
        w_ctrl_ext      = '0;
        w_step_ext      = '0;
        w_sum           = '0;
        w_ctrl_next     = r_ctrl;
        w_lock_cnt_next = r_lock_cnt;

        // The edge counter saturates instead of wrapping.
        if (w_edge && (r_edge_cnt != '1)) begin
            w_edge_cnt_inc = r_edge_cnt + 1'b1;
        end

        // Positive error means the VCO is too slow, so the control word goes up.
        w_error = $signed({1'b0, target_cnt}) - $signed({1'b0, r_meas_count});
        w_step  = w_error >>> GAIN_SHIFT;

        w_ctrl_ext = $signed({{(SUM_W - DIG_CTRL_V_WIDTH){1'b0}}, r_ctrl});
        w_step_ext = $signed({{(SUM_W - ERR_W){w_step[ERR_W-1]}}, w_step});
        w_sum      = w_ctrl_ext + w_step_ext;

        // Clamp to the control word range: negative sums go to 0, and oversized sums go to all ones.
        if (w_sum[SUM_W-1]) begin
            w_ctrl_next = '0;
        end else if (|w_sum[SUM_W-2:DIG_CTRL_V_WIDTH]) begin
            w_ctrl_next = '1;
        end else begin
            w_ctrl_next = w_sum[DIG_CTRL_V_WIDTH-1:0];
        end

        w_abs_err = w_error[ERR_W-1] ? ERR_W'(-w_error) : ERR_W'(w_error);
        w_in_tol  = (w_abs_err <= LOCK_TOL_W);

        if (r_lock_cnt != LOCK_MAX) begin
            w_lock_cnt_next = r_lock_cnt + 1'b1;
        end
    end

    // Measurement FSM: count edges over a window, then apply one control update per window.
    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_win_cnt      <= '0;
            r_edge_cnt     <= '0;
            r_meas_count   <= '0;
            r_ctrl         <= CTRL_INIT_W;
            r_update_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_lock_cnt     <= '0;
        end else begin
            r_update_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_win_cnt  <= '0;
                    r_edge_cnt <= '0;
                    if (en) begin
                        r_state <= ST_MEASURE;
                    end
                end

                ST_MEASURE: begin
                    if (!en) begin
                        // Aborted window: the control word and the last count hold, and lock is lost.
                        r_state    <= ST_IDLE;
                        r_win_cnt  <= '0;
                        r_edge_cnt <= '0;
                        r_lock_cnt <= '0;
                        r_locked   <= 1'b0;
                    end else if (r_win_cnt == WIN_LAST) begin
                        // Include an edge that arrives in the last window cycle.
                        r_meas_count <= w_edge_cnt_inc;
                        r_state      <= ST_UPDATE;
                    end else begin
                        r_win_cnt  <= r_win_cnt + 1'b1;
                        r_edge_cnt <= w_edge_cnt_inc;
                    end
                end

                ST_UPDATE: begin
                    // Dead cycle: an edge seen here is not counted in either window.
                    r_win_cnt      <= '0;
                    r_edge_cnt     <= '0;
                    r_ctrl         <= w_ctrl_next;
                    r_update_valid <= 1'b1;
                    if (w_in_tol) begin
                        r_lock_cnt <= w_lock_cnt_next;
                        r_locked   <= (w_lock_cnt_next == LOCK_MAX);
                    end else begin
                        r_lock_cnt <= '0;
                        r_locked   <= 1'b0;
                    end
                    r_state <= en ? ST_MEASURE : ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dig_ctrl_voltage = r_ctrl;
    assign meas_count       = r_meas_count;
    assign update_valid     = r_update_valid;
    assign locked           = r_locked;

endmodule
